// File: rtl/spi_pkg.sv
// Shared types for the SPI memory slave.
// FSM state encoding and header rw-bit values.
package spi_pkg;
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD_LD,
    RD,
    WR
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/spi_mem_slave_if.sv
// SPI pin bundle between an off-chip master and the memory slave.
// The slave drives miso and its pad output-enable.
interface spi_mem_slave_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output sclk, cs_n, mosi,
    input  miso, miso_oe
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output miso, miso_oe
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall detect.
// q is the level aligned with the rise/fall strobes.
module spi_sync_edge #(
  parameter int   STG     = 2,
  parameter logic INV     = 1'b0,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STG-1:0] sync;
  logic           prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= {STG{RST_VAL}};
      prev <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STG-2:0], din ^ INV};
      prev <= sync[STG-1];
      rise <= sync[STG-1] & ~prev;
      fall <= ~sync[STG-1] & prev;
    end
  end

  assign q = prev;
endmodule

// File: rtl/spi_mem_slave.sv
// SPI mode-0/2 slave giving burst read/write access to an inline RAM.
// Header {rw, addr} then data frames, MSB first, address auto-increments.
module spi_mem_slave
  import spi_pkg::*;
#(
  parameter int   DATA_W   = 8,
  parameter int   ADDR_W   = 7,
  parameter logic CPOL     = 1'b0,
  parameter int   SYNC_STG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_mem_slave_if.slave    spi,
  output logic              busy,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] last_addr
);
  localparam int HW = 1 + ADDR_W;
  localparam int MW = (HW > DATA_W) ? HW : DATA_W;
  localparam int CW = $clog2(MW);

  logic sck_q, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused;

  spi_sync_edge #(.STG(SYNC_STG), .INV(CPOL), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst_n(rst_n), .din(spi.sclk),
    .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STG(SYNC_STG), .INV(1'b0), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .din(spi.cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STG(SYNC_STG), .INV(1'b0), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .din(spi.mosi),
    .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused = ^{sck_q, cs_q, mosi_rise, mosi_fall};

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [ADDR_W-1:0]  addr, addr_n, last_n;
  logic [HW-1:0]      hdr, hdr_n;
  logic [DATA_W-1:0]  rx, rx_n, tx, tx_n, rd_data;
  logic               miso_q, miso_n, oe_q, oe_n;
  logic               busy_n, wp_n, we;

  logic [DATA_W-1:0]  mem [2**ADDR_W];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr;
    hdr_n   = hdr;
    rx_n    = rx;
    tx_n    = tx;
    miso_n  = miso_q;
    oe_n    = oe_q;
    busy_n  = busy;
    last_n  = last_addr;
    wp_n    = 1'b0;
    we      = 1'b0;
    // a deselect overrides any sclk edge seen in the same cycle
    if (cs_rise) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      miso_n  = 1'b0;
      busy_n  = 1'b0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: if (cs_fall) begin
          state_n = HDR;
          cnt_n   = '0;
          busy_n  = 1'b1;
          hdr_n   = '0;
        end
        HDR: if (sck_rise) begin
          hdr_n = {hdr[HW-2:0], mosi_s};
          if (cnt == CW'(HW-1)) begin
            cnt_n   = '0;
            addr_n  = hdr_n[ADDR_W-1:0];
            state_n = (hdr_n[HW-1] == RW_READ) ? RD_LD : WR;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        RD_LD: begin
          tx_n    = rd_data;
          oe_n    = 1'b1;
          cnt_n   = '0;
          state_n = RD;
        end
        RD: if (sck_fall) begin
          miso_n = tx[DATA_W-1];
          tx_n   = {tx[DATA_W-2:0], 1'b0};
          if (cnt == CW'(DATA_W-1)) begin
            cnt_n   = '0;
            last_n  = addr;
            addr_n  = addr + ADDR_W'(1);
            state_n = RD_LD;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        WR: if (sck_rise) begin
          rx_n = {rx[DATA_W-2:0], mosi_s};
          if (cnt == CW'(DATA_W-1)) begin
            cnt_n  = '0;
            we     = 1'b1;
            wp_n   = 1'b1;
            last_n = addr;
            addr_n = addr + ADDR_W'(1);
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '0;
      hdr       <= '0;
      rx        <= '0;
      tx        <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      busy      <= 1'b0;
      wr_pulse  <= 1'b0;
      last_addr <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      addr      <= addr_n;
      hdr       <= hdr_n;
      rx        <= rx_n;
      tx        <= tx_n;
      miso_q    <= miso_n;
      oe_q      <= oe_n;
      busy      <= busy_n;
      wr_pulse  <= wp_n;
      last_addr <= last_n;
    end
  end

  // read port follows the next address so RD_LD sees the prefetch target
  always_ff @(posedge clk) begin
    if (rst_n && we) mem[addr] <= rx_n;
    rd_data <= mem[addr_n];
  end

  assign spi.miso    = miso_q & oe_q;
  assign spi.miso_oe = oe_q;
endmodule
